// File: rtl/hw_px_packer_if.sv
// Pixel-in and packed-word-out handshake bundle for hw_px_packer.
// The master drives pixels and word_ready; the slave is the packer.
interface hw_px_packer_if #(
  parameter int PB  = 8,
  parameter int NPX = 4
);
  logic              px_in_ready;
  logic              px_in_valid;
  logic              px_in_last_x;
  logic              px_in_last_y;
  logic [PB-1:0]     px_in_data;
  logic              word_ready;
  logic              word_valid;
  logic [NPX*PB-1:0] word_data;
  logic [NPX-1:0]    word_keep;
  logic              word_eol;
  logic              word_last;

  modport master (
    input  px_in_ready,
    output px_in_valid,
    output px_in_last_x,
    output px_in_last_y,
    output px_in_data,
    output word_ready,
    input  word_valid,
    input  word_data,
    input  word_keep,
    input  word_eol,
    input  word_last
  );

  modport slave (
    output px_in_ready,
    input  px_in_valid,
    input  px_in_last_x,
    input  px_in_last_y,
    input  px_in_data,
    input  word_ready,
    output word_valid,
    output word_data,
    output word_keep,
    output word_eol,
    output word_last
  );
endinterface

// File: rtl/hw_px_packer.sv
// Packs NPX raster pixels per word, never across lines, checks frame
// geometry against cfg and flags completion of the final word.
module hw_px_packer #(
  parameter int XB  = 10,
  parameter int YB  = 10,
  parameter int PB  = 8,
  parameter int NPX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [XB-1:0] cfg_width,
  input  logic [YB-1:0] cfg_height,
  hw_px_packer_if.slave s,
  output logic          done,
  output logic          err_geom
);

  localparam int LB = (NPX > 1) ? $clog2(NPX) : 1;
  localparam int WB = NPX * PB;

  logic [XB-1:0]  r_x;
  logic [YB-1:0]  r_y;
  logic [LB-1:0]  r_lane;
  logic [WB-1:0]  r_acc;
  logic           r_fin;
  logic           r_wvalid;
  logic [WB-1:0]  r_wdata;
  logic [NPX-1:0] r_wkeep;
  logic           r_weol;
  logic           r_wlast;
  logic           r_done;
  logic           r_err;

  logic           w_ready;
  logic           w_xfer;
  logic           w_eol;
  logic           w_lasty;
  logic           w_cmpl;
  logic [WB-1:0]  w_word;
  logic [NPX-1:0] w_keep;

  // r_fin closes the input as soon as the final pixel is in
  assign w_ready = !r_done && !r_fin && (!r_wvalid || s.word_ready);
  assign w_xfer  = s.px_in_valid && w_ready;
  assign w_eol   = (r_x == cfg_width);
  assign w_lasty = (r_y == cfg_height);
  assign w_cmpl  = (int'(r_lane) == NPX - 1) || w_eol;

  always_comb begin
    w_word = r_acc;
    w_word[int'(r_lane)*PB +: PB] = s.px_in_data;
    for (int i = 0; i < NPX; i++) begin
      w_keep[i] = (i <= int'(r_lane));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x      <= '0;
      r_y      <= '0;
      r_lane   <= '0;
      r_acc    <= '0;
      r_fin    <= 1'b0;
      r_wvalid <= 1'b0;
      r_wdata  <= '0;
      r_wkeep  <= '0;
      r_weol   <= 1'b0;
      r_wlast  <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (r_wvalid && s.word_ready) begin
        r_wvalid <= 1'b0;
        if (r_wlast) r_done <= 1'b1;
      end
      if (w_xfer) begin
        if ((s.px_in_last_x != w_eol) || (s.px_in_last_y != w_lasty)) begin
          r_err <= 1'b1;
        end
        if (w_eol) begin
          r_x <= '0;
          if (w_lasty) begin
            r_y   <= '0;
            r_fin <= 1'b1;
          end else begin
            r_y <= r_y + YB'(1);
          end
        end else begin
          r_x <= r_x + XB'(1);
        end
        if (w_cmpl) begin
          // reload wins over the drain above: 1 px/clk sustained
          r_acc    <= '0;
          r_lane   <= '0;
          r_wvalid <= 1'b1;
          r_wdata  <= w_word;
          r_wkeep  <= w_keep;
          r_weol   <= w_eol;
          r_wlast  <= w_eol && w_lasty;
        end else begin
          r_acc  <= w_word;
          r_lane <= r_lane + LB'(1);
        end
      end
    end
  end

  assign s.px_in_ready = w_ready;
  assign s.word_valid  = r_wvalid;
  assign s.word_data   = r_wdata;
  assign s.word_keep   = r_wkeep;
  assign s.word_eol    = r_weol;
  assign s.word_last   = r_wlast;
  assign done          = r_done;
  assign err_geom      = r_err;

endmodule

// File: tb/tb_hw_px_packer.sv
// Directed bench for hw_px_packer: word tables for small frames, a
// reference packer for a large stalled frame, and reset/done corners.
module tb_hw_px_packer;
  localparam int PB  = 8;
  localparam int NPX = 4;
  localparam int XB  = 10;
  localparam int YB  = 10;
  localparam int W   = NPX * PB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [XB-1:0] cfg_width;
  logic [YB-1:0] cfg_height;
  logic          done;
  logic          err_geom;

  hw_px_packer_if #(.PB(PB), .NPX(NPX)) bus();

  hw_px_packer #(.XB(XB), .YB(YB), .PB(PB), .NPX(NPX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_width (cfg_width),
    .cfg_height(cfg_height),
    .s         (bus),
    .done      (done),
    .err_geom  (err_geom)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   data;
    logic [NPX-1:0] keep;
    logic           eol;
    logic           last;
  } word_t;

  typedef struct {
    int    fid;
    word_t w;
  } vec_t;

  int    checks = 0;
  int    failures = 0;
  int    rdy_mode = 0;
  word_t q_got[$];
  word_t q_exp[$];
  vec_t  tab[8];

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  initial begin
    bus.word_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.word_ready = 1'b1;
        1:       bus.word_ready = ($urandom_range(0, 99) >= 30);
        default: bus.word_ready = 1'b0;
      endcase
    end
  end

  logic  pv = 1'b0;
  word_t pw;
  logic  done_pend = 1'b0;

  always @(negedge clk) begin
    word_t cur;
    cur.data = bus.word_data;
    cur.keep = bus.word_keep;
    cur.eol  = bus.word_eol;
    cur.last = bus.word_last;
    if (!rst_n) begin
      pv = 1'b0;
      done_pend = 1'b0;
    end else begin
      if (done_pend) begin
        chk("done_after_last", 64'(done), 64'd1);
        done_pend = 1'b0;
      end
      if (pv) begin
        chk("stall_hold",
            64'({bus.word_valid, cur.data, cur.keep, cur.eol, cur.last}),
            64'({1'b1, pw.data, pw.keep, pw.eol, pw.last}));
      end
      if (bus.word_valid && bus.word_ready) begin
        q_got.push_back(cur);
        if (cur.last) begin
          chk("done_early", 64'(done), 64'd0);
          done_pend = 1'b1;
        end
      end
      pv = bus.word_valid && !bus.word_ready;
      pw = cur;
    end
  end

  task automatic do_reset(int w, int h);
    rst_n = 1'b0;
    bus.px_in_valid  = 1'b0;
    bus.px_in_last_x = 1'b0;
    bus.px_in_last_y = 1'b0;
    bus.px_in_data   = '0;
    cfg_width  = XB'(w - 1);
    cfg_height = YB'(h - 1);
    repeat (2) @(posedge clk);
    #1;
    q_got.delete();
    rst_n = 1'b1;
  endtask

  // Sends the first n pixels of a w x h raster; errx corrupts last_x on row 0
  task automatic drive_px(int w, int h, int errx, int n);
    for (int idx = 0; idx < n; idx++) begin
      int x;
      int y;
      int t;
      x = idx % w;
      y = idx / w;
      t = 0;
      bus.px_in_valid  = 1'b1;
      bus.px_in_data   = PB'(idx);
      bus.px_in_last_x = (x == w - 1) ^ (x == errx && y == 0);
      bus.px_in_last_y = (y == h - 1);
      forever begin
        @(negedge clk);
        if (bus.px_in_ready) break;
        t++;
        if (t > 500) break;
      end
      if (t > 500) begin
        chk("px_accept_timeout", 64'd0, 64'd1);
        bus.px_in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      if (x == errx && y == 0) chk("err_set", 64'(err_geom), 64'd1);
    end
    bus.px_in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!done && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", 64'(done), 64'd1);
    @(negedge clk);
  endtask

  task automatic check_tab(int fid);
    for (int i = 0; i < 8; i++) begin
      if (tab[i].fid == fid) begin
        if (q_got.size() == 0) begin
          chk("word_missing", 64'd0, 64'd1);
        end else begin
          word_t g;
          g = q_got.pop_front();
          chk("tab_data", 64'(g.data), 64'(tab[i].w.data));
          chk("tab_flags", 64'({g.keep, g.eol, g.last}),
              64'({tab[i].w.keep, tab[i].w.eol, tab[i].w.last}));
        end
      end
    end
    chk("extra_words", 64'(q_got.size()), 64'd0);
  endtask

  task automatic model_frame(int w, int h);
    word_t acc;
    int    lane;
    acc  = '{default: '0};
    lane = 0;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        acc.data[lane*PB +: PB] = PB'(y * w + x);
        acc.keep[lane] = 1'b1;
        if (lane == NPX - 1 || x == w - 1) begin
          acc.eol  = (x == w - 1);
          acc.last = (x == w - 1) && (y == h - 1);
          q_exp.push_back(acc);
          acc  = '{default: '0};
          lane = 0;
        end else begin
          lane++;
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    tab[0] = '{0, '{32'h03020100, 4'hF, 1'b1, 1'b0}};
    tab[1] = '{0, '{32'h07060504, 4'hF, 1'b1, 1'b0}};
    tab[2] = '{0, '{32'h0B0A0908, 4'hF, 1'b1, 1'b0}};
    tab[3] = '{0, '{32'h0F0E0D0C, 4'hF, 1'b1, 1'b1}};
    tab[4] = '{1, '{32'h03020100, 4'hF, 1'b0, 1'b0}};
    tab[5] = '{1, '{32'h00000504, 4'h3, 1'b1, 1'b0}};
    tab[6] = '{1, '{32'h09080706, 4'hF, 1'b0, 1'b0}};
    tab[7] = '{1, '{32'h00000B0A, 4'h3, 1'b1, 1'b1}};

    do_reset(4, 4);
    chk("rst_outputs",
        64'({bus.word_valid, bus.word_data, bus.word_keep, bus.word_eol,
             bus.word_last, done, err_geom}), 64'd0);
    chk("rst_ready", 64'(bus.px_in_ready), 64'd1);

    drive_px(4, 4, -1, 16);
    wait_done();
    check_tab(0);
    chk("err_clean_4x4", 64'(err_geom), 64'd0);

    do_reset(6, 2);
    drive_px(6, 2, -1, 12);
    wait_done();
    check_tab(1);
    chk("err_clean_6x2", 64'(err_geom), 64'd0);

    do_reset(6, 2);
    drive_px(6, 2, 2, 12);
    wait_done();
    check_tab(1);
    chk("err_sticky", 64'(err_geom), 64'd1);

    bad = 0;
    bus.px_in_valid = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (bus.px_in_ready || bus.word_valid || !done) bad++;
    end
    bus.px_in_valid = 1'b0;
    chk("post_done_idle", 64'(bad), 64'd0);
    chk("post_done_no_words", 64'(q_got.size()), 64'd0);

    do_reset(4, 4);
    rdy_mode = 2;
    @(posedge clk);
    #1;
    drive_px(4, 4, -1, 4);
    repeat (2) @(posedge clk);
    #1;
    chk("stalled_word_valid", 64'({bus.word_valid, bus.px_in_ready}), 64'b10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outputs",
        64'({bus.word_valid, bus.word_data, bus.word_keep, bus.word_eol,
             bus.word_last, done, err_geom}), 64'd0);
    rdy_mode = 0;
    do_reset(4, 4);
    drive_px(4, 4, -1, 16);
    wait_done();
    check_tab(0);
    chk("err_clean_rerun", 64'(err_geom), 64'd0);

    do_reset(1024, 24);
    rdy_mode = 1;
    q_exp.delete();
    model_frame(1024, 24);
    drive_px(1024, 24, -1, 1024 * 24);
    wait_done();
    rdy_mode = 0;
    chk("rand_count", 64'(q_got.size()), 64'(q_exp.size()));
    bad = 0;
    while (q_got.size() > 0 && q_exp.size() > 0) begin
      word_t g;
      word_t e;
      g = q_got.pop_front();
      e = q_exp.pop_front();
      if (g != e) begin
        bad++;
        if (bad < 5) begin
          $display("FAIL rand_word actual=%0h/%0h/%0b%0b required=%0h/%0h/%0b%0b",
                   g.data, g.keep, g.eol, g.last, e.data, e.keep, e.eol, e.last);
        end
      end
    end
    chk("rand_words_bad", 64'(bad), 64'd0);
    chk("err_clean_rand", 64'(err_geom), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
